// File: rtl/moving_avg.sv
// Boxcar moving average over DEPTH samples, paired with an external ring buffer delay line.
// Define MOVING_AVG_ROUND_EN to round the average to nearest instead of flooring it.
module moving_avg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           valid_i,
   output logic                           ready_o,
   input  logic [WIDTH-1:0]               data_i,
   input  logic [WIDTH-1:0]               oldest_i,
   input  logic                           flush_i,
   output logic                           enable_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [WIDTH-1:0]               avg_o,
   output logic [WIDTH+$clog2(DEPTH)-1:0] sum_o,
   output logic                           filled_o,
   output logic                           dbg_state_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = WIDTH + PTR_W;

   typedef enum logic {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [SUM_W-1:0]   sum_q;
   logic [SUM_W-1:0]   sum_next;
   logic [SUM_W-1:0]   sub_val;
   logic [WIDTH-1:0]   avg_next;
   logic               acc;
   logic               fill_last;
   logic               filled_next;

   // Handshake: a sample moves when valid_i && ready_o; a result leaves when
   // valid_o && ready_i. ready_o never depends on valid_i, and flush blocks both.
   assign ready_o  = (!valid_o || ready_i) && !flush_i;
   assign acc      = valid_i && ready_o;
   assign enable_o = acc;

   assign fill_last   = (fill_cnt_q == PTR_W'(DEPTH - 1));
   assign filled_next = (state_q == S_RUN) || fill_last;

   // During warm-up the buffer slot leaving the window holds stale data, so it is masked.
   assign sub_val  = (state_q == S_RUN) ? SUM_W'(oldest_i) : '0;
   assign sum_next = sum_q + SUM_W'(data_i) - sub_val;

`ifdef MOVING_AVG_ROUND_EN
   logic [SUM_W:0] sum_rnd;
   assign sum_rnd  = {1'b0, sum_next} + (SUM_W+1)'(DEPTH / 2);
   assign avg_next = WIDTH'(sum_rnd >> PTR_W);
`else
   assign avg_next = WIDTH'(sum_next >> PTR_W);
`endif

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      if (acc && state_q == S_FILL) begin
         fill_cnt_d = fill_cnt_q + PTR_W'(1);
         if (fill_last) begin
            state_d = S_RUN;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_FILL;
         fill_cnt_q <= '0;
         sum_q      <= '0;
      end else if (flush_i) begin
         state_q    <= S_FILL;
         fill_cnt_q <= '0;
         sum_q      <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         if (acc) begin
            sum_q <= sum_next;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o  <= 1'b0;
         avg_o    <= '0;
         sum_o    <= '0;
         filled_o <= 1'b0;
      end else if (flush_i) begin
         valid_o  <= 1'b0;
         filled_o <= 1'b0;
      end else if (acc) begin
         valid_o  <= 1'b1;
         avg_o    <= avg_next;
         sum_o    <= sum_next;
         filled_o <= filled_next;
      end else if (valid_o && ready_i) begin
         valid_o  <= 1'b0;
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_moving_avg.sv
// Directed bench for moving_avg at WIDTH=8, DEPTH=4; build with MOVING_AVG_ROUND_EN for the rounding variant.
module tb_moving_avg;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SUM_W = WIDTH + 2;

   logic              clk_i;
   logic              rst_ni;
   logic              valid_i;
   logic              ready_o;
   logic [WIDTH-1:0]  data_i;
   logic [WIDTH-1:0]  oldest_i;
   logic              flush_i;
   logic              enable_o;
   logic              valid_o;
   logic              ready_i;
   logic [WIDTH-1:0]  avg_o;
   logic [SUM_W-1:0]  sum_o;
   logic              filled_o;
   logic              dbg_state_o;

   int n_tests;
   int n_fail;
   int en_cnt;

   moving_avg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .oldest_i    (oldest_i),
      .flush_i     (flush_i),
      .enable_o    (enable_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .avg_o       (avg_o),
      .sum_o       (sum_o),
      .filled_o    (filled_o),
      .dbg_state_o (dbg_state_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) begin
      if (enable_o === 1'b1) en_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Presents one sample, checks it is taken this cycle, and returns #1 after the accept edge.
   task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] old, input string tag);
      valid_i  = 1'b1;
      data_i   = d;
      oldest_i = old;
      #1;
      chk({tag, "_enable"}, 32'(enable_o), 32'd1);
      @(posedge clk_i);
      #1;
      valid_i  = 1'b0;
      oldest_i = 'x;
   endtask

   task automatic idle();
      @(posedge clk_i);
      #1;
   endtask

   logic [WIDTH-1:0] warm_d[4]   = '{8'd10, 8'd20, 8'd30, 8'd40};
   logic [SUM_W-1:0] warm_sum[4] = '{10'd10, 10'd30, 10'd60, 10'd100};
`ifdef MOVING_AVG_ROUND_EN
   logic [WIDTH-1:0] warm_avg[4] = '{8'd3, 8'd8, 8'd15, 8'd25};
`else
   logic [WIDTH-1:0] warm_avg[4] = '{8'd2, 8'd7, 8'd15, 8'd25};
`endif
   logic             warm_fil[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   logic [WIDTH-1:0] fs_old[8]   = '{8'd30, 8'd40, 8'd50, 8'd60, 8'd255, 8'd255, 8'd255, 8'd255};
   logic [SUM_W-1:0] fs_sum[8]   = '{10'd405, 10'd620, 10'd825, 10'd1020, 10'd1020, 10'd1020, 10'd1020, 10'd1020};

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      en_cnt   = 0;
      rst_ni   = 1'b0;
      valid_i  = 1'b0;
      data_i   = '0;
      oldest_i = 'x;
      flush_i  = 1'b0;
      ready_i  = 1'b1;
      idle();
      idle();
      chk("rst_valid",  32'(valid_o),  32'd0);
      chk("rst_sum",    32'(sum_o),    32'd0);
      chk("rst_avg",    32'(avg_o),    32'd0);
      chk("rst_filled", 32'(filled_o), 32'd0);
      rst_ni = 1'b1;
      #1;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_state", 32'(dbg_state_o), 32'd0);

      // Warm-up with unknown oldest_i
      en_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         send(warm_d[i], 'x, $sformatf("warm%0d", i));
         chk($sformatf("warm%0d_valid", i),  32'(valid_o),  32'd1);
         chk($sformatf("warm%0d_sum", i),    32'(sum_o),    32'(warm_sum[i]));
         chk($sformatf("warm%0d_avg", i),    32'(avg_o),    32'(warm_avg[i]));
         chk($sformatf("warm%0d_filled", i), 32'(filled_o), 32'(warm_fil[i]));
      end
      chk("warm_enable_pulses", 32'(en_cnt), 32'd4);
      chk("warm_state_run", 32'(dbg_state_o), 32'd1);

      // Steady state
      send(8'd50, 8'd10, "st0");
      chk("st0_sum", 32'(sum_o), 32'd140);
      chk("st0_avg", 32'(avg_o), 32'd35);
      chk("st0_filled", 32'(filled_o), 32'd1);
      send(8'd60, 8'd20, "st1");
      chk("st1_sum", 32'(sum_o), 32'd180);
      chk("st1_avg", 32'(avg_o), 32'd45);

      // Full scale: window becomes all 255
      for (int i = 0; i < 8; i++) begin
         send(8'd255, fs_old[i], $sformatf("fs%0d", i));
         chk($sformatf("fs%0d_sum", i), 32'(sum_o), 32'(fs_sum[i]));
      end
      chk("fs_avg", 32'(avg_o), 32'd255);
      chk("fs_filled", 32'(filled_o), 32'd1);

      // Result consumed with no new sample drops valid_o
      idle();
      chk("drain_valid", 32'(valid_o), 32'd0);

      // Backpressure
      ready_i = 1'b0;
      send(8'd7, 8'd255, "bp_in");
      chk("bp_in_sum", 32'(sum_o), 32'd772);
      chk("bp_in_avg", 32'(avg_o), 32'd193);
      valid_i  = 1'b1;
      data_i   = 8'd11;
      oldest_i = 8'd255;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_ready", i),  32'(ready_o),  32'd0);
         chk($sformatf("bp%0d_enable", i), 32'(enable_o), 32'd0);
         idle();
         chk($sformatf("bp%0d_valid", i),  32'(valid_o),  32'd1);
         chk($sformatf("bp%0d_sum", i),    32'(sum_o),    32'd772);
         chk($sformatf("bp%0d_avg", i),    32'(avg_o),    32'd193);
      end
      ready_i = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(ready_o), 32'd1);
      send(8'd11, 8'd255, "bp_rel");
      chk("bp_rel_sum", 32'(sum_o), 32'd528);
      chk("bp_rel_avg", 32'(avg_o), 32'd132);

      // Flush while presenting a sample in RUN
      flush_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'd99;
      #1;
      chk("flush_enable", 32'(enable_o), 32'd0);
      chk("flush_ready",  32'(ready_o),  32'd0);
      idle();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush_valid",  32'(valid_o),  32'd0);
      chk("flush_filled", 32'(filled_o), 32'd0);
      chk("flush_state",  32'(dbg_state_o), 32'd0);
      send(8'd8, 8'd123, "postflush");
      chk("postflush_sum",    32'(sum_o),    32'd8);
      chk("postflush_avg",    32'(avg_o),    32'd2);
      chk("postflush_filled", 32'(filled_o), 32'd0);

      // Asynchronous reset mid-stream
      send(8'd20, 'x, "prerst");
      chk("prerst_sum", 32'(sum_o), 32'd28);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midrst_valid",  32'(valid_o),  32'd0);
      chk("midrst_sum",    32'(sum_o),    32'd0);
      chk("midrst_avg",    32'(avg_o),    32'd0);
      chk("midrst_filled", 32'(filled_o), 32'd0);
      idle();
      rst_ni = 1'b1;
      send(8'd40, 8'd77, "postrst");
      chk("postrst_sum",    32'(sum_o),    32'd40);
      chk("postrst_avg",    32'(avg_o),    32'd10);
      chk("postrst_filled", 32'(filled_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/moving_avg.md
# moving_avg

Boxcar moving-average stage that sits directly downstream of the ring buffer delay line. On every accepted sample it adds the newest sample, subtracts the sample leaving the window (the ring buffer's delayed output), and registers the running sum and the window average behind a valid/ready handshake. The block drives the ring buffer's enable so both advance in lockstep. It tracks the warm-up window itself, so uninitialised buffer contents never reach the sum.

## Interface

- WIDTH, 8: sample width in bits, unsigned; must equal the ring buffer WIDTH.
- DEPTH, 8: window length; power of two, at least 2; must equal the ring buffer DEPTH. PTR_W = $clog2(DEPTH).
- clk_i  input  1  single clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  upstream sample valid.
- ready_o  output  1  block can accept a sample this cycle.
- data_i  input  WIDTH  newest sample; also routed to the ring buffer data_i.
- oldest_i  input  WIDTH  sample leaving the window; connected to the ring buffer data_o.
- flush_i  input  1  synchronous window clear.
- enable_o  output  1  ring buffer enable; high exactly on accept cycles.
- valid_o  output  1  avg_o, sum_o and filled_o hold a result.
- ready_i  input  1  downstream accepts the result.
- avg_o  output  WIDTH  window average.
- sum_o  output  WIDTH+PTR_W  running window sum.
- filled_o  output  1  result covers a full window of DEPTH real samples.

## Operation

- Accept: acc = valid_i && ready_o && !flush_i. enable_o = acc.
- ready_o = (!valid_o || ready_i) && !flush_i, combinational.
- States: FILL (reset state) and RUN. fill_cnt counts 0..DEPTH-1 and is used only in FILL.
- FILL on acc: sum_next = sum + data_i. oldest_i is ignored and treated as 0. fill_cnt increments. On the acc with fill_cnt == DEPTH-1, go to RUN.
- RUN on acc: sum_next = sum + data_i - oldest_i. Stay in RUN.
- Width: sum is WIDTH+PTR_W bits unsigned. The maximum value DEPTH*(2^WIDTH-1) fits, so the block never overflows or wraps. Subtraction is never negative because oldest_i was previously added.
- avg = sum_next >> PTR_W (floor), unless ROUND is enabled (see Configuration).
- Output register on acc: sum_o <= sum_next, avg_o <= avg, valid_o <= 1. filled_o <= 1 if the state was RUN or this acc completes FILL, otherwise 0.
- Output hold: if valid_o && ready_i && !acc, then valid_o <= 0. While valid_o && !ready_i, all outputs stay stable.
- Flush: when flush_i is high, the next edge sets sum 0, fill_cnt 0, state FILL, valid_o 0, filled_o 0. Any sample presented that cycle is dropped and enable_o stays 0. Flush takes priority over every other event. Ring buffer contents are left stale; the following FILL pass masks them.

## Timing

- Reset (asynchronous, immediate): state FILL, sum 0, fill_cnt 0, valid_o 0, avg_o 0, sum_o 0, filled_o 0.
- Since ready_o = !valid_o right after reset, ready_o = 1 and enable_o follows valid_i.
- Reset asserted mid-stream: a pending result is lost and the window restarts from FILL.
- Latency: one cycle from the accept edge to valid_o / avg_o.
- Throughput: one sample per cycle while ready_i is held high.
- oldest_i is sampled in the same cycle as acc. This matches the combinational ring buffer read of the slot about to be overwritten.
- enable_o and ready_o are combinational from valid_i, ready_i, flush_i and the output register. There is no combinational path from data_i to any output.

## Configuration

- MOVING_AVG_ROUND_EN defined: avg = (sum_next + DEPTH/2) >> PTR_W, computed at WIDTH+PTR_W+1 bits. The result is at most 2^WIDTH-1, so no saturation is needed.
- Not defined: avg = floor(sum_next / DEPTH).
- sum_o is identical in both builds.

## Test plan

All scenarios use WIDTH=8, DEPTH=4 and floor build unless noted.

- Warm-up: after reset, feed 10, 20, 30, 40 with ready_i=1 and oldest_i=X. Required: avg_o 2, 7, 15, 25; sum_o 10, 30, 60, 100; filled_o 0, 0, 0, 1; enable_o pulses 4 times.
- Steady state: continue with 50 (oldest_i=10) and 60 (oldest_i=20). Required: sum_o 140, 180; avg_o 35, 45; filled_o 1.
- Full scale: 8 samples of 255 with correct oldest_i. Required: sum_o 1020, avg_o 255, no wrap.
- Backpressure: hold ready_i=0 while valid_o=1. Required: ready_o=0, enable_o=0, outputs frozen for 5 cycles. On release, the next sample is accepted in the same cycle.
- Flush and reset:
  - flush_i with valid_i=1 in RUN: enable_o=0, valid_o=0 next cycle. Then sample 8: avg_o 2, sum_o 8, filled_o 0.
  - rst_ni low mid-stream: all outputs 0 immediately.
- Rounding build (MOVING_AVG_ROUND_EN): warm-up 10, 20, 30, 40. Required: avg_o 3, 8, 15, 25.
